// File: rtl/pe_driver.sv
// pe_driver: buffers signed operand pairs and sequences them one at a time into an
// attached multiply-accumulate PE, returning the accumulated dot product.
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   wr_en, wr_a, wr_b  - push one signed operand pair into the buffer (IDLE only)
//   wr_full            - buffer holds DEPTH entries
//   start, len         - run a dot product over the first len buffered entries
//   busy               - run in progress
//   pe_rst             - clears the PE accumulator (also high while rst is high)
//   pe_a, pe_b         - operands presented to the PE, held until pe_done
//   pe_ready           - one-cycle issue strobe to the PE
//   pe_done, pe_result - PE completion pulse and its accumulator value
//   res_valid, res_data- one-cycle result strobe and held result
//   err                - one-cycle error strobe (bad len or PE timeout)
module pe_driver #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic signed [7:0]  wr_a,
    input  logic signed [7:0]  wr_b,
    output logic               wr_full,
    input  logic               start,
    input  logic [4:0]         len,
    output logic               busy,
    output logic               pe_rst,
    output logic signed [7:0]  pe_a,
    output logic signed [7:0]  pe_b,
    output logic               pe_ready,
    input  logic               pe_done,
    input  logic signed [23:0] pe_result,
    output logic               res_valid,
    output logic signed [23:0] res_data,
    output logic               err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StClr, StIssue, StWait, StGap, StFinish} state_e;

    state_e             state_q;
    logic [CW-1:0]      count_q;
    logic [AW-1:0]      idx_q;
    logic [4:0]         len_q;
    logic [TW-1:0]      timer_q;
    logic signed [7:0]  buf_a [DEPTH];
    logic signed [7:0]  buf_b [DEPTH];
    logic signed [7:0]  pe_a_q;
    logic signed [7:0]  pe_b_q;
    logic signed [23:0] res_data_q;
    logic               res_valid_q;
    logic               err_q;
    logic               pe_rst_q;

    logic wr_accept;
    logic start_ok;
    logic last_elem;

    assign start_ok  = (32'(len) != 32'd0) && (32'(len) <= 32'(count_q));
    // start wins over a same-cycle write
    assign wr_accept = !rst && (state_q == StIdle) && wr_en && !start && (32'(count_q) < DEPTH);
    assign last_elem = (32'(idx_q) + 32'd1) == 32'(len_q);

    // Operand storage; contents are don't-care once count is cleared, so no reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_a[count_q[AW-1:0]] <= wr_a;
            buf_b[count_q[AW-1:0]] <= wr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            timer_q     <= '0;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pe_rst_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pe_rst_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (start_ok) begin
                            len_q    <= len;
                            idx_q    <= '0;
                            pe_rst_q <= 1'b1;
                            state_q  <= StClr;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (wr_accept) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                StClr: begin
                    pe_a_q  <= buf_a[idx_q];
                    pe_b_q  <= buf_b[idx_q];
                    state_q <= StIssue;
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (pe_done) begin
                        idx_q <= idx_q + AW'(1);
                        if (last_elem) begin
                            res_data_q  <= pe_result;
                            res_valid_q <= 1'b1;
                            state_q     <= StFinish;
                        end else begin
                            state_q <= StGap;
                        end
                    end else if (timer_q == TW'(TIMEOUT - 2)) begin
                        // Window counts from the issue cycle, so err lands TIMEOUT
                        // cycles after pe_ready.
                        err_q    <= 1'b1;
                        pe_rst_q <= 1'b1;
                        count_q  <= '0;
                        state_q  <= StIdle;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StGap: begin
                    pe_a_q  <= buf_a[idx_q];
                    pe_b_q  <= buf_b[idx_q];
                    state_q <= StIssue;
                end
                StFinish: begin
                    count_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_full   = (32'(count_q) == DEPTH);
    assign busy      = (state_q != StIdle);
    assign pe_ready  = (state_q == StIssue);
    assign pe_rst    = rst | pe_rst_q;
    assign pe_a      = pe_a_q;
    assign pe_b      = pe_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pe_driver.sv
// Bench for pe_driver: a 12-cycle-per-MAC PE model, table-driven vectors, hand-written
// corner sequences and randomized runs checked against a queue-based reference model.
module tb_pe_driver;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_en = 1'b0;
    logic signed [7:0]  wr_a = '0;
    logic signed [7:0]  wr_b = '0;
    logic               wr_full;
    logic               start = 1'b0;
    logic [4:0]         len_in = '0;
    logic               busy;
    logic               pe_rst;
    logic signed [7:0]  pe_a;
    logic signed [7:0]  pe_b;
    logic               pe_ready;
    logic               pe_done = 1'b0;
    logic signed [23:0] pe_result = '0;
    logic               res_valid;
    logic signed [23:0] res_data;
    logic               err;

    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_b[$];
    bit pe_en = 1'b1;

    pe_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_full   (wr_full),
        .start     (start),
        .len       (len_in),
        .busy      (busy),
        .pe_rst    (pe_rst),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_ready  (pe_ready),
        .pe_done   (pe_done),
        .pe_result (pe_result),
        .res_valid (res_valid),
        .res_data  (res_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // PE model: pe_done 10 cycles after pe_ready (12-cycle MAC period with the
    // driver's gap), accumulator cleared by pe_rst, operands must hold until done.
    int                 pe_cnt = 0;
    logic signed [7:0]  cap_a = '0;
    logic signed [7:0]  cap_b = '0;
    logic signed [23:0] acc = '0;

    always @(posedge clk) begin
        pe_done <= 1'b0;
        if (pe_done) begin
            check("pe_a_hold", {24'h0, pe_a}, {24'h0, cap_a});
            check("pe_b_hold", {24'h0, pe_b}, {24'h0, cap_b});
        end
        if (pe_rst) begin
            acc    <= '0;
            pe_cnt <= 0;
        end else if (pe_ready) begin
            cap_a  <= pe_a;
            cap_b  <= pe_b;
            pe_cnt <= 1;
        end else if (pe_cnt == 9) begin
            pe_cnt <= 0;
            if (pe_en) begin
                acc       <= acc + cap_a * cap_b;
                pe_result <= acc + cap_a * cap_b;
                pe_done   <= 1'b1;
            end
        end else if (pe_cnt != 0) begin
            pe_cnt <= pe_cnt + 1;
        end
    end

    task automatic push(input int a, input int b);
        wr_en = 1'b1;
        wr_a  = 8'(a);
        wr_b  = 8'(b);
        step();
        wr_en = 1'b0;
        if (q_a.size() < DEPTH) begin
            q_a.push_back(a);
            q_b.push_back(b);
        end
    endtask

    // Start a run of n elements; expectation comes from the model queue and,
    // when use_tab is set, also from a table entry.
    task automatic do_run(input string tag, input int n, input bit use_tab, input bit tab_err,
                          input logic [23:0] tab_res, input bit wr_during);
        bit m_err;
        int sum;
        int lat;
        bit seen_err;
        m_err = (n < 1) || (n > q_a.size());
        sum = 0;
        if (!m_err) for (int i = 0; i < n; i++) sum += q_a[i] * q_b[i];
        start  = 1'b1;
        len_in = 5'(n);
        if (wr_during) begin
            wr_en = 1'b1;
            wr_a  = 8'sd77;
            wr_b  = 8'sd77;
        end
        step();
        start = 1'b0;
        if (m_err) begin
            check({tag, "_err"}, err, 1);
            check({tag, "_err_busy"}, busy, 0);
            if (use_tab) check({tag, "_tab_err"}, err, tab_err);
            step();
            check({tag, "_err_pulse"}, err, 0);
        end else begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_clr_pe_rst"}, pe_rst, 1);
            lat = 1;
            seen_err = 1'b0;
            while (!res_valid && lat < 12 * n + 40) begin
                if (err) seen_err = 1'b1;
                step();
                lat++;
            end
            check({tag, "_latency"}, lat, 12 * n + 1);
            check({tag, "_res"}, {8'h0, res_data}, {8'h0, sum[23:0]});
            check({tag, "_no_err"}, seen_err, 0);
            if (use_tab && !tab_err) check({tag, "_tab_res"}, {8'h0, res_data}, {8'h0, tab_res});
            if (wr_during) begin
                check({tag, "_wr_full_busy"}, wr_full, 0);
                wr_en = 1'b0;
            end
            step();
            check({tag, "_valid_pulse"}, res_valid, 0);
            check({tag, "_idle"}, busy, 0);
            check({tag, "_cleared"}, wr_full, 0);
            q_a.delete();
            q_b.delete();
        end
    endtask

    typedef struct {
        int          npush;
        int          a[4];
        int          b[4];
        int          len;
        bit          exp_err;
        logic [23:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        int nr;
        bit seen;

        vecs[0] = '{3, '{3, -2, 7, 0}, '{4, 5, -1, 0}, 3, 1'b0, 24'hFFFFFB};
        vecs[1] = '{2, '{1, 2, 0, 0}, '{1, 2, 0, 0}, 4, 1'b1, 24'h000000};
        vecs[2] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 1'b1, 24'h000000};
        vecs[3] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 2, 1'b0, 24'h000005};
        vecs[4] = '{4, '{127, -128, 5, 0}, '{127, 127, -6, 9}, 2, 1'b0, 24'hFFFF81};
        vecs[5] = '{1, '{-1, 0, 0, 0}, '{-1, 0, 0, 0}, 1, 1'b0, 24'h000001};

        // Reset state
        #1;
        check("rst_pe_rst_comb", pe_rst, 1);
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_wr_full", wr_full, 0);
        check("rst_pe_ready", pe_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err, 0);
        check("rst_pe_a", {24'h0, pe_a}, 0);
        check("rst_res_data", {8'h0, res_data}, 0);
        rst = 1'b0;
        step();
        check("rst_release_pe_rst", pe_rst, 0);

        // Table-driven vectors
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].npush; j++) push(vecs[v].a[j], vecs[v].b[j]);
            do_run($sformatf("vec%0d", v), vecs[v].len, 1'b1, vecs[v].exp_err,
                   vecs[v].exp_res, 1'b0);
        end

        // Full buffer: extra push dropped, full-length run of max-magnitude products
        for (int j = 0; j < DEPTH; j++) push(-128, -128);
        check("full_flag", wr_full, 1);
        push(1, 1);
        check("full_still", wr_full, 1);
        do_run("full_run", DEPTH, 1'b1, 1'b0, 24'h040000, 1'b0);

        // Writes with start and while busy must not land
        for (int j = 0; j < DEPTH - 1; j++) push(1, 1);
        check("busy_wr_pre", wr_full, 0);
        do_run("busy_wr", 1, 1'b1, 1'b0, 24'h000001, 1'b1);

        // PE never answers: timeout
        pe_en = 1'b0;
        push(1, 1);
        start  = 1'b1;
        len_in = 5'd1;
        step();
        start = 1'b0;
        lat = 0;
        while (!pe_ready && lat < 10) begin
            step();
            lat++;
        end
        check("to_issue", pe_ready, 1);
        n = 0;
        seen = 1'b0;
        while (!err && n < TIMEOUT + 10) begin
            if (res_valid) seen = 1'b1;
            step();
            n++;
        end
        check("to_latency", n, TIMEOUT);
        check("to_pe_rst", pe_rst, 1);
        check("to_busy", busy, 0);
        check("to_no_valid", seen | res_valid, 0);
        step();
        check("to_err_pulse", err, 0);
        check("to_pe_rst_pulse", pe_rst, 0);
        q_a.delete();
        q_b.delete();
        pe_en = 1'b1;

        // Reset during element 2 of a 3-element run
        push(1, 2);
        push(3, 4);
        push(5, 6);
        start  = 1'b1;
        len_in = 5'd3;
        step();
        start = 1'b0;
        nr = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (pe_ready) nr++;
            if (nr == 2) break;
        end
        check("rr_second_issue", nr, 2);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("rr_pe_rst_comb", pe_rst, 1);
        step();
        check("rr_busy", busy, 0);
        check("rr_pe_ready", pe_ready, 0);
        check("rr_res_valid", res_valid, 0);
        check("rr_err", err, 0);
        check("rr_pe_a", {24'h0, pe_a}, 0);
        check("rr_pe_b", {24'h0, pe_b}, 0);
        check("rr_res_data", {8'h0, res_data}, 0);
        check("rr_wr_full", wr_full, 0);
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        seen = 1'b0;
        repeat (40) begin
            step();
            if (res_valid || err) seen = 1'b1;
        end
        check("rr_quiet", seen, 0);
        push(2, 3);
        do_run("rr_fresh", 1, 1'b1, 1'b0, 24'h000006, 1'b0);

        // Randomized runs against the queue model
        for (int r = 0; r < 14; r++) begin
            n = $urandom_range(0, DEPTH - q_a.size());
            for (int j = 0; j < n; j++)
                push(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            do_run($sformatf("rnd%0d", r), int'($urandom_range(0, q_a.size() + 2)), 1'b0,
                   1'b0, 24'h0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
